// File: rtl/rainbow_pkg.sv
// Shared types and helpers for the rainbow LED sequencer.
// RAINBOW_BOUNCE_EN selects whether bounce mode exists in the mode sequence.
package rainbow_pkg;

    localparam int NUM_PHASES = 6;
    localparam logic [NUM_PHASES-1:0] DEF_INIT_PATTERN = 6'b000111;

    typedef enum logic [1:0] {
        MODE_ROT_L  = 2'd0,
        MODE_ROT_R  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } seq_state_e;

    function automatic logic [NUM_PHASES-1:0] rot_l(
        input logic [NUM_PHASES-1:0] p
    );
        return {p[NUM_PHASES-2:0], p[NUM_PHASES-1]};
    endfunction

    function automatic logic [NUM_PHASES-1:0] rot_r(
        input logic [NUM_PHASES-1:0] p
    );
        return {p[0], p[NUM_PHASES-1:1]};
    endfunction

    function automatic mode_e next_mode(input mode_e m);
        logic [1:0] nxt;
`ifdef RAINBOW_BOUNCE_EN
        nxt = m + 2'd1;
`else
        // Bounce is skipped: 0 -> 1 -> 3 -> 0
        unique case (m)
            MODE_ROT_L: nxt = MODE_ROT_R;
            MODE_ROT_R: nxt = MODE_BLINK;
            default:    nxt = MODE_ROT_L;
        endcase
`endif
        return mode_e'(nxt);
    endfunction

endpackage

// File: rtl/rainbow_sequencer_if.sv
// Control/status bundle between the rainbow sequencer and its user.
// The master drives run and button pulses; the slave returns pattern state.
interface rainbow_sequencer_if;
    import rainbow_pkg::*;

    logic                  run;
    logic                  btn_mode;
    logic                  btn_speed;
    logic [NUM_PHASES-1:0] pattern;
    logic                  step;
    logic [1:0]            mode;
    logic [1:0]            speed;

    modport master (
        output run, btn_mode, btn_speed,
        input  pattern, step, mode, speed
    );

    modport slave (
        input  run, btn_mode, btn_speed,
        output pattern, step, mode, speed
    );

endinterface

// File: rtl/rainbow_tick.sv
// Step prescaler: counts enabled cycles and pulses tick at the
// terminal count (BASE_INTERVAL >> speed) - 1, then wraps.
module rainbow_tick #(
    parameter int BASE_INTERVAL = 2000000,
    localparam int CW = $clog2(BASE_INTERVAL)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       clear,
    input  logic [1:0] speed,
    output logic       tick
);

    logic [CW-1:0] cnt;
    logic [CW-1:0] term;

    always_comb begin
        term = CW'((BASE_INTERVAL >> speed) - 1);
        // A clear on the same cycle suppresses the tick
        tick = enable && !clear && (cnt == term);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/rainbow_sequencer.sv
// Six-phase rainbow LED sequencer: run/pause FSM, mode and speed
// registers, pattern update. Optional bounce mode via RAINBOW_BOUNCE_EN.
module rainbow_sequencer
    import rainbow_pkg::*;
#(
    parameter int BASE_INTERVAL = 2000000,
    parameter logic [NUM_PHASES-1:0] INIT_PATTERN = DEF_INIT_PATTERN
) (
    input logic          clk,
    input logic          rst,
    rainbow_sequencer_if.slave bus
);

    seq_state_e            state;
    mode_e                 mode_q;
    logic [1:0]            speed_q;
    logic [NUM_PHASES-1:0] pattern_q;
    logic [NUM_PHASES-1:0] pattern_nxt;
    logic                  step_q;
    logic                  tick;
    logic                  cnt_clear;
    logic                  cnt_en;

`ifdef RAINBOW_BOUNCE_EN
    logic [2:0] bounce_cnt;
    logic       dir_right;
`endif

    assign cnt_clear = bus.btn_mode | bus.btn_speed;
    assign cnt_en    = (state == RUN);

    rainbow_tick #(
        .BASE_INTERVAL (BASE_INTERVAL)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (cnt_en),
        .clear  (cnt_clear),
        .speed  (speed_q),
        .tick   (tick)
    );

    always_comb begin
        pattern_nxt = pattern_q;
        unique case (1'b1)
            (mode_q == MODE_ROT_L):  pattern_nxt = rot_l(pattern_q);
            (mode_q == MODE_ROT_R):  pattern_nxt = rot_r(pattern_q);
`ifdef RAINBOW_BOUNCE_EN
            (mode_q == MODE_BOUNCE): pattern_nxt = dir_right ?
                                         rot_r(pattern_q) :
                                         rot_l(pattern_q);
`else
            (mode_q == MODE_BOUNCE): pattern_nxt = pattern_q;
`endif
            (mode_q == MODE_BLINK):  pattern_nxt = ~pattern_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mode_q    <= MODE_ROT_L;
            speed_q   <= 2'd0;
            pattern_q <= INIT_PATTERN;
            step_q    <= 1'b0;
`ifdef RAINBOW_BOUNCE_EN
            bounce_cnt <= 3'd0;
            dir_right  <= 1'b0;
`endif
        end else begin
            step_q <= 1'b0;

            case (state)
                IDLE:    if (bus.run)  state <= RUN;
                RUN:     if (!bus.run) state <= PAUSE;
                PAUSE:   if (bus.run)  state <= RUN;
                default: state <= IDLE;
            endcase

            if (bus.btn_speed) begin
                speed_q <= speed_q + 2'd1;
            end

            // Buttons win over a coincident tick; tick is already gated
            if (bus.btn_mode) begin
                mode_q    <= next_mode(mode_q);
                pattern_q <= INIT_PATTERN;
`ifdef RAINBOW_BOUNCE_EN
                bounce_cnt <= 3'd0;
                dir_right  <= 1'b0;
`endif
            end else if (tick) begin
                step_q    <= 1'b1;
                pattern_q <= pattern_nxt;
`ifdef RAINBOW_BOUNCE_EN
                if (mode_q == MODE_BOUNCE) begin
                    if (bounce_cnt == 3'd5) begin
                        bounce_cnt <= 3'd0;
                        dir_right  <= ~dir_right;
                    end else begin
                        bounce_cnt <= bounce_cnt + 3'd1;
                    end
                end
`endif
            end
        end
    end

    assign bus.pattern = pattern_q;
    assign bus.step    = step_q;
    assign bus.mode    = mode_q;
    assign bus.speed   = speed_q;

endmodule
